// File: rtl/mem_pkg.sv
// Shared types for the memory request unit: FSM states, access sizes, requestor ids.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RESP  = 3'd2,
    ACK   = 3'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  // Size 2'b11 has no legal encoding and is reported like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: lane enables and write replication for a request, plus lane
// shift and sign/zero extension of returned read data.
// Latency: combinational. Backpressure: none.
// Ports: req_size/req_addr_lo/req_wdata -> req_sel/req_wdata_rep (request side);
//        rsp_size/rsp_addr_lo/rsp_unsigned/rsp_rdata -> rsp_rdata_ext (response side).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_sel,
  output logic [31:0] req_wdata_rep,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic        rsp_unsigned,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_ext
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    req_sel       = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        req_sel       = 4'b0001 << req_addr_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        req_sel       = 4'b0011 << req_addr_lo;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0 before extending.
  assign shifted = rsp_rdata >> {rsp_addr_lo, 3'b000};
  assign sign_b  = ~rsp_unsigned & shifted[7];
  assign sign_h  = ~rsp_unsigned & shifted[15];

  always_comb begin
    rsp_rdata_ext = shifted;
    case (rsp_size)
      SIZE_BYTE: rsp_rdata_ext = {{24{sign_b}}, shifted[7:0]};
      SIZE_HALF: rsp_rdata_ext = {{16{sign_h}}, shifted[15:0]};
      default:   rsp_rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Round-robin arbiter between fetch and load/store requests driving one bus transaction at a time.
// Latency: ack 3 cycles after acceptance when unstalled (+1 per busy cycle); misaligned ack after 1.
// Backpressure: bus_busy holds the strobe and its address/lanes/data stable in ISSUE.
// Optional: MEMREQ_TIMEOUT_EN aborts ISSUE with err after TIMEOUT consecutive busy cycles.
// Ports: instr_* fetch requestor, data_* load/store requestor, err shared with both acks,
//        bus_* manager interface, state debug view of the FSM. All outputs are registered.
module mem_request_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_unsigned,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ack,
  output logic [31:0]       data_rdata,
  output logic              err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_busy,
  output logic [2:0]        state
);

  if (ADDR_W < 3 || TIMEOUT < 1) begin : g_param_chk
    $error("mem_request_unit: ADDR_W must be >= 3 and TIMEOUT >= 1");
  end

  state_t  state_q, state_d;
  req_id_t last_grant_q, last_grant_d;
  req_id_t lat_id_q, lat_id_d;
  logic [1:0] lat_size_q, lat_size_d;
  logic [1:0] lat_addr_lo_q, lat_addr_lo_d;
  logic       lat_unsigned_q, lat_unsigned_d;
  logic       lat_we_q, lat_we_d;

  logic              instr_ack_d, data_ack_d, err_d;
  logic [31:0]       instr_rdata_d, data_rdata_d;
  logic              bus_read_d, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [31:0]       bus_wdata_d;
  logic [3:0]        bus_sel_d;

`ifdef MEMREQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
`endif

  // Candidate request presented in IDLE. Fetches are always aligned-word reads.
  logic              pick_data;
  logic [ADDR_W-1:0] cand_addr;
  logic [1:0]        cand_size;
  logic              cand_we;
  logic              cand_unsigned;
  logic [31:0]       cand_wdata;
  logic [3:0]        cand_sel;
  logic [31:0]       cand_wdata_rep;
  logic [31:0]       rdata_ext;

  // On conflict the requestor that was not granted last wins.
  assign pick_data     = data_req && (!instr_req || (last_grant_q == REQ_INSTR));
  assign cand_addr     = pick_data ? data_addr : instr_addr;
  assign cand_size     = pick_data ? data_size : SIZE_WORD;
  assign cand_we       = pick_data && data_we;
  assign cand_unsigned = pick_data && data_unsigned;
  assign cand_wdata    = data_wdata;

  mem_lane_align u_lane_align (
    .req_size      (cand_size),
    .req_addr_lo   (cand_addr[1:0]),
    .req_wdata     (cand_wdata),
    .req_sel       (cand_sel),
    .req_wdata_rep (cand_wdata_rep),
    .rsp_size      (lat_size_q),
    .rsp_addr_lo   (lat_addr_lo_q),
    .rsp_unsigned  (lat_unsigned_q),
    .rsp_rdata     (bus_rdata),
    .rsp_rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    lat_id_d       = lat_id_q;
    lat_size_d     = lat_size_q;
    lat_addr_lo_d  = lat_addr_lo_q;
    lat_unsigned_d = lat_unsigned_q;
    lat_we_d       = lat_we_q;
    instr_ack_d    = 1'b0;
    data_ack_d     = 1'b0;
    err_d          = 1'b0;
    instr_rdata_d  = instr_rdata;
    data_rdata_d   = data_rdata;
    bus_read_d     = bus_read;
    bus_write_d    = bus_write;
    bus_addr_d     = bus_addr;
    bus_wdata_d    = bus_wdata;
    bus_sel_d      = bus_sel;
`ifdef MEMREQ_TIMEOUT_EN
    busy_cnt_d     = busy_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (instr_req || data_req) begin
          lat_id_d       = pick_data ? REQ_DATA : REQ_INSTR;
          last_grant_d   = pick_data ? REQ_DATA : REQ_INSTR;
          lat_size_d     = cand_size;
          lat_addr_lo_d  = cand_addr[1:0];
          lat_unsigned_d = cand_unsigned;
          lat_we_d       = cand_we;
          if (is_misaligned(cand_size, cand_addr[1:0])) begin
            // Reject without touching the bus.
            state_d = ACK;
            err_d   = 1'b1;
            if (pick_data) begin
              data_ack_d   = 1'b1;
              data_rdata_d = 32'h0;
            end else begin
              instr_ack_d   = 1'b1;
              instr_rdata_d = 32'h0;
            end
          end else begin
            state_d     = ISSUE;
            bus_read_d  = !cand_we;
            bus_write_d = cand_we;
            bus_addr_d  = {cand_addr[ADDR_W-1:2], 2'b00};
            bus_sel_d   = cand_sel;
            bus_wdata_d = cand_wdata_rep;
`ifdef MEMREQ_TIMEOUT_EN
            busy_cnt_d  = '0;
`endif
          end
        end
      end

      ISSUE: begin
        if (!bus_busy) begin
          state_d     = RESP;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
        end
`ifdef MEMREQ_TIMEOUT_EN
        else if (busy_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ACK;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          err_d       = 1'b1;
          if (lat_id_q == REQ_DATA) begin
            data_ack_d   = 1'b1;
            data_rdata_d = 32'h0;
          end else begin
            instr_ack_d   = 1'b1;
            instr_rdata_d = 32'h0;
          end
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        state_d = ACK;
        if (lat_id_q == REQ_DATA) begin
          data_ack_d   = 1'b1;
          data_rdata_d = lat_we_q ? 32'h0 : rdata_ext;
        end else begin
          instr_ack_d   = 1'b1;
          instr_rdata_d = rdata_ext;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_INSTR;
      lat_id_q       <= REQ_INSTR;
      lat_size_q     <= SIZE_BYTE;
      lat_addr_lo_q  <= 2'b00;
      lat_unsigned_q <= 1'b0;
      lat_we_q       <= 1'b0;
      instr_ack      <= 1'b0;
      data_ack       <= 1'b0;
      err            <= 1'b0;
      instr_rdata    <= 32'h0;
      data_rdata     <= 32'h0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= 32'h0;
      bus_sel        <= 4'h0;
`ifdef MEMREQ_TIMEOUT_EN
      busy_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      lat_id_q       <= lat_id_d;
      lat_size_q     <= lat_size_d;
      lat_addr_lo_q  <= lat_addr_lo_d;
      lat_unsigned_q <= lat_unsigned_d;
      lat_we_q       <= lat_we_d;
      instr_ack      <= instr_ack_d;
      data_ack       <= data_ack_d;
      err            <= err_d;
      instr_rdata    <= instr_rdata_d;
      data_rdata     <= data_rdata_d;
      bus_read       <= bus_read_d;
      bus_write      <= bus_write_d;
      bus_addr       <= bus_addr_d;
      bus_wdata      <= bus_wdata_d;
      bus_sel        <= bus_sel_d;
`ifdef MEMREQ_TIMEOUT_EN
      busy_cnt_q     <= busy_cnt_d;
`endif
    end
  end

  assign state = state_q;

endmodule
